ppmn_demod: RTL

PPMN_DEMOD -- requirements
Module: ppmn_demod

---
 rtl/ppmn_demod.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ppmn_demod.sv
// PPM-N receiver: slot-count argmax demodulation, preamble/delimiter sync, length field and data output.
// Optional macro PPMN_DEMOD_ABORT_EN: abort a packet after two consecutive erased data symbols.
module ppmn_demod #(
    parameter int SYM_BITS  = 4,
    parameter int CHIP_BITS = 4,
    parameter int SYNC_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    din,
    input  logic                    rx_start,
    input  logic [CHIP_BITS:0]      corr_threshold,
    output logic                    busy,
    output logic                    packet_detected,
    output logic [2*SYM_BITS-1:0]   pkt_len,
    output logic                    dout_valid,
    output logic [SYM_BITS-1:0]     dout,
    output logic                    dout_erasure,
    output logic                    packet_done,
    output logic                    packet_aborted
);
    localparam int PW = SYM_BITS + CHIP_BITS;
    localparam int LW = 2 * SYM_BITS;

    typedef enum logic [1:0] {IDLE, SEARCH, LEN, DATA} state_t;

    state_t                 state_q;
    logic [PW-1:0]          pos_q;
    logic [CHIP_BITS:0]     slot_cnt_q;
    logic [CHIP_BITS:0]     best_cnt_q;
    logic [SYM_BITS-1:0]    best_idx_q;
    logic                   skip_q;
    logic [3:0]             sync_q;
    logic                   len_phase_q;
    logic [SYM_BITS-1:0]    len_hi_q;
    logic [LW-1:0]          data_cnt_q;
    logic                   detected_q;
    logic [LW-1:0]          pkt_len_q;
    logic                   dout_valid_q;
    logic [SYM_BITS-1:0]    dout_q;
    logic                   dout_erasure_q;
    logic                   packet_done_q;

    logic [CHIP_BITS-1:0]   chip;
    logic [SYM_BITS-1:0]    slot;
    logic [CHIP_BITS:0]     slot_acc;
    logic                   take;
    logic [CHIP_BITS:0]     cand_cnt;
    logic [SYM_BITS-1:0]    cand_idx;
    logic                   slot_end;
    logic                   sym_end;
    logic                   erased;
    logic [LW-1:0]          len_full;

    always_comb begin
        chip     = pos_q[CHIP_BITS-1:0];
        slot     = pos_q[PW-1:CHIP_BITS];
        slot_acc = slot_cnt_q + (CHIP_BITS+1)'(din);
        // first slot of a symbol always seeds the running maximum; strict compare keeps the lowest index on ties
        take     = (slot == '0) || (slot_acc > best_cnt_q);
        cand_cnt = take ? slot_acc : best_cnt_q;
        cand_idx = take ? slot : best_idx_q;
        slot_end = &chip;
        sym_end  = slot_end && (&slot);
        erased   = cand_cnt < corr_threshold;
        len_full = {len_hi_q, cand_idx};
    end

`ifdef PPMN_DEMOD_ABORT_EN
    logic prev_erased_q;
    logic packet_aborted_q;
    assign packet_aborted = packet_aborted_q;
`else
    assign packet_aborted = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            pos_q          <= '0;
            slot_cnt_q     <= '0;
            best_cnt_q     <= '0;
            best_idx_q     <= '0;
            skip_q         <= 1'b0;
            sync_q         <= '0;
            len_phase_q    <= 1'b0;
            len_hi_q       <= '0;
            data_cnt_q     <= '0;
            detected_q     <= 1'b0;
            pkt_len_q      <= '0;
            dout_valid_q   <= 1'b0;
            dout_q         <= '0;
            dout_erasure_q <= 1'b0;
            packet_done_q  <= 1'b0;
`ifdef PPMN_DEMOD_ABORT_EN
            prev_erased_q    <= 1'b0;
            packet_aborted_q <= 1'b0;
`endif
        end else begin
            dout_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
`ifdef PPMN_DEMOD_ABORT_EN
            packet_aborted_q <= 1'b0;
`endif
            if (rx_start) begin
                state_q     <= SEARCH;
                pos_q       <= '0;
                slot_cnt_q  <= '0;
                best_cnt_q  <= '0;
                best_idx_q  <= '0;
                skip_q      <= 1'b0;
                sync_q      <= '0;
                len_phase_q <= 1'b0;
                data_cnt_q  <= '0;
                detected_q  <= 1'b0;
`ifdef PPMN_DEMOD_ABORT_EN
                prev_erased_q <= 1'b0;
`endif
            end else if (skip_q) begin
                skip_q <= 1'b0;
            end else if (state_q != IDLE) begin
                pos_q <= pos_q + PW'(1);
                if (slot_end) begin
                    slot_cnt_q <= '0;
                    best_cnt_q <= cand_cnt;
                    best_idx_q <= cand_idx;
                end else begin
                    slot_cnt_q <= slot_acc;
                end
                if (sym_end) begin
                    case (state_q)
                        SEARCH: begin
                            if (erased) begin
                                // drop one sample so the window creeps toward the true symbol boundary
                                sync_q <= '0;
                                skip_q <= 1'b1;
                            end else if (cand_idx == '0) begin
                                if (sync_q < 4'(SYNC_LEN))
                                    sync_q <= sync_q + 4'd1;
                            end else if (&cand_idx) begin
                                if (sync_q == 4'(SYNC_LEN)) begin
                                    state_q     <= LEN;
                                    detected_q  <= 1'b1;
                                    len_phase_q <= 1'b0;
                                end
                                sync_q <= '0;
                            end else begin
                                sync_q <= '0;
                            end
                        end
                        LEN: begin
                            if (!len_phase_q) begin
                                len_hi_q    <= cand_idx;
                                len_phase_q <= 1'b1;
                            end else begin
                                pkt_len_q  <= len_full;
                                data_cnt_q <= '0;
`ifdef PPMN_DEMOD_ABORT_EN
                                prev_erased_q <= 1'b0;
`endif
                                if (len_full == '0) begin
                                    packet_done_q <= 1'b1;
                                    detected_q    <= 1'b0;
                                    state_q       <= IDLE;
                                end else begin
                                    state_q <= DATA;
                                end
                            end
                        end
                        DATA: begin
                            dout_valid_q   <= 1'b1;
                            dout_q         <= cand_idx;
                            dout_erasure_q <= erased;
                            data_cnt_q     <= data_cnt_q + LW'(1);
`ifdef PPMN_DEMOD_ABORT_EN
                            prev_erased_q  <= erased;
                            if (erased && prev_erased_q) begin
                                packet_aborted_q <= 1'b1;
                                detected_q       <= 1'b0;
                                sync_q           <= '0;
                                state_q          <= SEARCH;
                            end else
`endif
                            if (data_cnt_q + LW'(1) == pkt_len_q) begin
                                packet_done_q <= 1'b1;
                                detected_q    <= 1'b0;
                                state_q       <= IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign busy            = (state_q != IDLE);
    assign packet_detected = detected_q;
    assign pkt_len         = pkt_len_q;
    assign dout_valid      = dout_valid_q;
    assign dout            = dout_q;
    assign dout_erasure    = dout_erasure_q;
    assign packet_done     = packet_done_q;
endmodule
